// File: rtl/vga_pkg.sv
// Shared VGA read-side definitions: default 640x480@60 timing, pixel types and the
// control word that travels alongside each buffer read.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_FB_WIDTH  = 320;
  localparam int unsigned DEF_FB_HEIGHT = 240;

  localparam int unsigned H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Control bits that must arrive at the output register together with rData
  typedef struct packed {
    logic       vis;
    logic       fetch;
    logic       hs_n;
    logic       vs_n;
    logic [9:0] h;
    logic [9:0] v;
  } ctrl_t;

  // Idle control word: blanked, syncs deasserted
  localparam ctrl_t CTRL_IDLE = '{vis: 1'b0, fetch: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                  h: 10'd0, v: 10'd0};

  // Keep the top 4 bits of each RGB565 field
  function automatic rgb444_t rgb565_to_444(input logic [15:0] d);
    rgb444_t p;
    p.r = d[15:12];
    p.g = d[10:7];
    p.b = d[4:1];
    return p;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raw VGA raster: free-running h/v counters and the undelayed vis/hs_n/vs_n flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       vis,
  output logic       hs_n,
  output logic       vs_n
);

  localparam int unsigned HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSS = H_VISIBLE + H_FP;
  localparam int unsigned HSE = HSS + H_SYNC - 1;
  localparam int unsigned VSS = V_VISIBLE + V_FP;
  localparam int unsigned VSE = VSS + V_SYNC - 1;

  // Horizontal counter wraps every line; vertical advances on each horizontal wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(HT - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(VT - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Visible region and active-low sync windows decoded from the counters
  always_comb begin
    vis  = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    hs_n = !((h_cnt >= 10'(HSS)) && (h_cnt <= 10'(HSE)));
    vs_n = !((v_cnt >= 10'(VSS)) && (v_cnt <= 10'(VSE)));
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Read side of the camera frame buffer: VGA timing, buffer address generation
// (2x upscale or 1:1 window), latency-matched control pipeline and RGB444 output.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned FB_WIDTH   = DEF_FB_WIDTH,
  parameter int unsigned FB_HEIGHT  = DEF_FB_HEIGHT,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upscale,
  output logic        oe,
  output logic [16:0] rAddr,
  input  logic [15:0] rData,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        vis;
  logic        hs_n;
  logic        vs_n;
  logic        mode_q;
  logic        mode_cur;
  logic        fetch;
  logic [16:0] addr_next;
  ctrl_t       s1;
  ctrl_t       dly [RD_LATENCY];
  ctrl_t       c;
  rgb444_t     px;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk   (clk),
    .reset (reset),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .vis   (vis),
    .hs_n  (hs_n),
    .vs_n  (vs_n)
  );

  // Mode taken from the live input at the frame origin so pixel (0,0) already uses it
  always_comb begin
    mode_cur = ((h_cnt == '0) && (v_cnt == '0)) ? upscale : mode_q;
  end

  // Hold the frame's display mode until the next frame origin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= 1'b0;
    else       mode_q <= mode_cur;
  end

  // Fetch decision and buffer address for the current raster position
  always_comb begin
    if (mode_cur) begin
      fetch     = vis;
      addr_next = 17'(v_cnt >> 1) * 17'(FB_WIDTH) + 17'(h_cnt >> 1);
    end else begin
      fetch     = (h_cnt < 10'(FB_WIDTH)) && (v_cnt < 10'(FB_HEIGHT));
      addr_next = 17'(v_cnt) * 17'(FB_WIDTH) + 17'(h_cnt);
    end
  end

  // Stage 1: issue the read and capture the matching control word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe    <= 1'b0;
      rAddr <= '0;
      s1    <= CTRL_IDLE;
    end else begin
      oe <= fetch;
      if (fetch) rAddr <= addr_next;
      s1 <= '{vis: vis, fetch: fetch, hs_n: hs_n, vs_n: vs_n, h: h_cnt, v: v_cnt};
    end
  end

  // Delay control by the buffer read latency; idle words keep syncs high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) dly[i] <= CTRL_IDLE;
    end else begin
      dly[0] <= s1;
      for (int unsigned i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  // Pixel colour: buffer data only where it was actually fetched, black elsewhere
  always_comb begin
    c  = dly[RD_LATENCY-1];
    px = (c.vis && c.fetch) ? rgb565_to_444(rData) : '0;
  end

  // Output register: pixel and syncs change together on one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de          <= 1'b0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      x_pixel     <= '0;
      y_pixel     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      de          <= c.vis;
      h_sync      <= c.hs_n;
      v_sync      <= c.vs_n;
      x_pixel     <= c.h;
      y_pixel     <= c.v;
      red         <= px.r;
      green       <= px.g;
      blue        <= px.b;
      frame_start <= c.vis && (c.h == '0) && (c.v == '0);
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Scoreboard bench: a full-size instance (read latency 1) and a reduced-geometry
// instance (read latency 3) checked every cycle against a raster model.
module tb_vga_framebuffer_reader;

  typedef struct {
    int hv, hfp, hs, hbp, vv, vfp, vs, vbp, fbw, fbh, rdl;
  } geom_t;

  typedef struct packed {
    logic        oe;
    logic [16:0] raddr;
    logic        hs;
    logic        vs;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        fs;
  } obs_t;

  localparam obs_t IDLE = '{oe: 1'b0, raddr: 17'd0, hs: 1'b1, vs: 1'b1, de: 1'b0,
                            x: 10'd0, y: 10'd0, r: 4'd0, g: 4'd0, b: 4'd0, fs: 1'b0};

  localparam int S_RD = 3;
  localparam int F_RD = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic upscale = 1'b1;
  always #20 clk = ~clk;

  // Small instance
  logic        oe_s, hs_s, vs_s, de_s, fs_s;
  logic [16:0] raddr_s;
  logic [15:0] rdata_s;
  logic [9:0]  x_s, y_s;
  logic [3:0]  r_s, g_s, b_s;
  // Full-size instance
  logic        oe_f, hs_f, vs_f, de_f, fs_f;
  logic [16:0] raddr_f;
  logic [15:0] rdata_f;
  logic [9:0]  x_f, y_f;
  logic [3:0]  r_f, g_f, b_f;

  vga_framebuffer_reader #(
    .H_VISIBLE (64), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_VISIBLE (20), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .FB_WIDTH  (32), .FB_HEIGHT (10), .RD_LATENCY (S_RD)
  ) dut_s (
    .clk (clk), .reset (reset), .upscale (upscale), .oe (oe_s), .rAddr (raddr_s),
    .rData (rdata_s), .h_sync (hs_s), .v_sync (vs_s), .de (de_s), .x_pixel (x_s),
    .y_pixel (y_s), .red (r_s), .green (g_s), .blue (b_s), .frame_start (fs_s)
  );

  vga_framebuffer_reader #(
    .RD_LATENCY (F_RD)
  ) dut_f (
    .clk (clk), .reset (reset), .upscale (upscale), .oe (oe_f), .rAddr (raddr_f),
    .rData (rdata_f), .h_sync (hs_f), .v_sync (vs_f), .de (de_f), .x_pixel (x_f),
    .y_pixel (y_f), .red (r_f), .green (g_f), .blue (b_f), .frame_start (fs_f)
  );

  // Buffer contents: a scrambled function of the address
  function automatic logic [15:0] mem_data(input int a);
    int t;
    t = a * 40503 + 12345;
    return t[15:0];
  endfunction

  // Buffer models with the configured read latency
  logic [16:0] pipe_s [S_RD];
  logic [16:0] pipe_f [F_RD];
  always @(posedge clk) begin
    pipe_s[0] <= raddr_s;
    for (int i = 1; i < S_RD; i++) pipe_s[i] <= pipe_s[i-1];
    pipe_f[0] <= raddr_f;
    for (int i = 1; i < F_RD; i++) pipe_f[i] <= pipe_f[i-1];
  end
  assign rdata_s = mem_data(int'(pipe_s[S_RD-1]));
  assign rdata_f = mem_data(int'(pipe_f[F_RD-1]));

  obs_t act_s, act_f;
  assign act_s = {oe_s, raddr_s, hs_s, vs_s, de_s, x_s, y_s, r_s, g_s, b_s, fs_s};
  assign act_f = {oe_f, raddr_f, hs_f, vs_f, de_f, x_f, y_f, r_f, g_f, b_f, fs_f};

  obs_t q_s[$];
  obs_t q_f[$];
  bit   up_hist[$];     // up_hist[i] = upscale seen at edge i+1 after reset release
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_edge = 0;
  int   last_s = 0;
  int   last_f = 0;
  geom_t gs, gf;

  function automatic void cmp(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endfunction

  function automatic void cmp_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic bit fetch_of(input geom_t g, input int h, input int v, input bit m);
    if (m) return (h < g.hv) && (v < g.vv);
    return (h < g.fbw) && (v < g.fbh);
  endfunction

  function automatic int addr_of(input geom_t g, input int h, input int v, input bit m);
    if (m) return (v / 2) * g.fbw + (h / 2);
    return v * g.fbw + h;
  endfunction

  // Expected observation just after edge n (n >= 1) since reset release
  task automatic build_exp(input geom_t g, input int n, inout int last, output obs_t e);
    int ht, vt, ft, k, h, v;
    bit m, vis, fe;
    logic [15:0] d;
    ht = g.hv + g.hfp + g.hs + g.hbp;
    vt = g.vv + g.vfp + g.vs + g.vbp;
    ft = ht * vt;
    e  = IDLE;
    // Read request reflects the raster position one cycle back
    k  = n - 1;
    h  = k % ht;
    v  = (k / ht) % vt;
    m  = up_hist[(k / ft) * ft];
    fe = fetch_of(g, h, v, m);
    if (fe) last = addr_of(g, h, v, m);
    e.oe    = fe;
    e.raddr = 17'(last);
    // Pixel outputs reflect the raster position latency+2 cycles back
    k = n - (g.rdl + 2);
    if (k >= 0) begin
      h   = k % ht;
      v   = (k / ht) % vt;
      m   = up_hist[(k / ft) * ft];
      vis = (h < g.hv) && (v < g.vv);
      fe  = fetch_of(g, h, v, m);
      e.hs = !((h >= g.hv + g.hfp) && (h < g.hv + g.hfp + g.hs));
      e.vs = !((v >= g.vv + g.vfp) && (v < g.vv + g.vfp + g.vs));
      e.de = vis;
      e.x  = 10'(h);
      e.y  = 10'(v);
      if (vis && fe) begin
        d   = mem_data(addr_of(g, h, v, m));
        e.r = d[15:12];
        e.g = d[10:7];
        e.b = d[4:1];
      end
      e.fs = vis && (h == 0) && (v == 0);
    end
  endtask

  // One stimulus cycle: drive inputs on the falling edge, queue what the next rising edge must show
  task automatic step(input bit rst, input bit u);
    bit   prev;
    obs_t e_s, e_f;
    @(negedge clk);
    prev    = reset;
    reset   = rst;
    upscale = u;
    if (rst) begin
      n_edge = 0;
      last_s = 0;
      last_f = 0;
      up_hist.delete();
      q_s.push_back(IDLE);
      q_f.push_back(IDLE);
      if (!prev) begin
        #1;
        cmp("async_reset_small", act_s, IDLE);
        cmp("async_reset_full", act_f, IDLE);
      end
    end else begin
      n_edge++;
      up_hist.push_back(u);
      build_exp(gs, n_edge, last_s, e_s);
      build_exp(gf, n_edge, last_f, e_f);
      q_s.push_back(e_s);
      q_f.push_back(e_f);
    end
  endtask

  // Monitor: compare each presented output cycle with the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_s.size() > 0) cmp("pixel_small", act_s, q_s.pop_front());
      if (q_f.size() > 0) cmp("pixel_full", act_f, q_f.pop_front());
    end
  end

  initial begin
    bit u;
    int extra;
    gs = '{64, 4, 6, 6, 20, 2, 2, 3, 32, 10, S_RD};
    gf = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240, F_RD};

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

    // Upscaled first frame; later frames follow random mid-frame toggles
    u = 1'b1;
    step(1'b0, u);
    extra = 11000 + int'($urandom_range(0, 999));
    for (int i = 0; i < extra; i++) begin
      if ($urandom_range(0, 299) == 0) u = ~u;
      step(1'b0, u);
    end

    // Reset mid-frame for three cycles, restart in 1:1 mode
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    u = 1'b0;
    step(1'b0, u);
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 299) == 0) u = ~u;
      step(1'b0, u);
    end

    repeat (3) @(negedge clk);
    cmp_int("drain_small", q_s.size(), 0);
    cmp_int("drain_full", q_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
